pll_dyn_phase_ctrl: RTL and testbench

Run-time controller for the PLL's dynamic phase-shift port and lock supervision; sits beside the PLL wrapper in the config clock domain (PLL input reference, 50 MHz).
- Accepts phase-shift requests per output channel, generates PHASE_SEL/PHASE_DIR/PHASE_STEP_N/LOAD_PHASE sequences, and waits for relock.
- Tracks the phase position of each channel.
- Auto-recovers a PLL that loses or never gains lock by pulsing its reset.

---
 rtl/pll_ctrl_pkg.sv | 44 ++++
 rtl/pll_lock_watchdog.sv | 37 +++
 rtl/pll_dyn_phase_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pll_dyn_phase_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types, default timing constants and phase-position arithmetic for the
// PLL dynamic phase-shift controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STEP_LO,
        STEP_HI,
        LOAD,
        WAIT_LOCK,
        RECOVER
    } pll_state_e;

    localparam int unsigned DEF_NUM_CH       = 5;
    localparam int unsigned DEF_STEP_W       = 8;
    localparam int unsigned DEF_POS_W        = 10;
    localparam int unsigned DEF_PHASE_WRAP   = 920;
    localparam int unsigned DEF_STEP_PULSE   = 2;
    localparam int unsigned DEF_STEP_GAP     = 4;
    localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
    localparam int unsigned DEF_RST_CYCLES   = 100;

    // New position after moving 'steps' in direction 'dir', folded into [0, wrap).
    function automatic int unsigned phase_wrap(
        input int unsigned pos,
        input int unsigned steps,
        input logic        dir,
        input int unsigned wrap
    );
        int unsigned res;
        if (dir) begin
            res = pos + steps;
            if (res >= wrap) res = res - wrap;
        end else if (steps > pos) begin
            res = pos + wrap - steps;
        end else begin
            res = pos - steps;
        end
        return res;
    endfunction

endpackage

// File: rtl/pll_lock_watchdog.sv
// Lock synchroniser plus a consecutive-low-lock timeout counter.
module pll_lock_watchdog #(
    parameter int unsigned LOCK_TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic pll_lock,
    output logic lock_s,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic             lock_meta;
    logic [CNT_W-1:0] cnt;
    logic             expire_c;

    assign expire_c = !clear && !lock_s && (cnt == CNT_W'(LOCK_TIMEOUT - 1));

    // Count cycles of synced lock low while supervising; restart on lock or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            cnt       <= '0;
            timeout   <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            timeout   <= expire_c;
            if (clear || lock_s || expire_c) cnt <= '0;
            else                             cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pll_dyn_phase_ctrl.sv
// Dynamic phase-shift sequencer with per-channel position tracking and
// automatic PLL reset recovery on lock loss.
module pll_dyn_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned STEP_W       = DEF_STEP_W,
    parameter int unsigned POS_W        = DEF_POS_W,
    parameter int unsigned PHASE_WRAP   = DEF_PHASE_WRAP,
    parameter int unsigned STEP_PULSE   = DEF_STEP_PULSE,
    parameter int unsigned STEP_GAP     = DEF_STEP_GAP,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_chan,
    input  logic                    req_dir,
    input  logic [STEP_W-1:0]       req_steps,
    output logic                    done,
    output logic                    err,
    output logic                    busy,
    input  logic                    pll_lock,
    output logic [2:0]              phase_sel,
    output logic                    phase_dir,
    output logic                    phase_step_n,
    output logic                    load_phase,
    output logic                    pll_rst,
    output logic [NUM_CH*POS_W-1:0] phase_pos,
    output logic [7:0]              recover_cnt
);

    localparam int unsigned TMR_MAX0 = (STEP_PULSE > STEP_GAP) ? STEP_PULSE : STEP_GAP;
    localparam int unsigned TMR_MAX  = (TMR_MAX0 > RST_CYCLES) ? TMR_MAX0 : RST_CYCLES;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

    pll_state_e        state, state_d;
    logic [TMR_W-1:0]  tmr, tmr_d;
    logic [STEP_W-1:0] rem, rem_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [2:0]        chan_q, chan_d;
    logic              dir_q, dir_d;
    logic [POS_W-1:0]  pos_q [NUM_CH];
    logic [POS_W-1:0]  pos_d [NUM_CH];
    logic [7:0]        rcnt_d;
    logic              err_d, done_d;
    logic [2:0]        sel_d;
    logic              pdir_d;
    logic              enter_recover;
    logic              lock_s, timeout, wd_clear;

    // Lock is only supervised while waiting for it or sitting idle.
    assign wd_clear = !(state == INIT || state == IDLE || state == WAIT_LOCK);

    pll_lock_watchdog #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .pll_lock (pll_lock),
        .lock_s   (lock_s),
        .timeout  (timeout)
    );

    always_comb begin
        state_d       = state;
        tmr_d         = tmr;
        rem_d         = rem;
        steps_d       = steps_q;
        chan_d        = chan_q;
        dir_d         = dir_q;
        pos_d         = pos_q;
        rcnt_d        = recover_cnt;
        err_d         = err;
        done_d        = 1'b0;
        sel_d         = phase_sel;
        pdir_d        = phase_dir;
        enter_recover = 1'b0;

        case (state)
            INIT: begin
                if (lock_s)       state_d = IDLE;
                else if (timeout) enter_recover = 1'b1;
            end
            IDLE: begin
                // Requests win over a coincident timeout so a handshake is never dropped.
                if (req_valid) begin
                    err_d   = 1'b0;
                    chan_d  = req_chan;
                    dir_d   = req_dir;
                    steps_d = req_steps;
                    rem_d   = req_steps;
                    if (32'(req_chan) >= NUM_CH) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (req_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        sel_d   = req_chan;
                        pdir_d  = req_dir;
                    end
                end else if (timeout) begin
                    enter_recover = 1'b1;
                end
            end
            SETUP: begin
                state_d = STEP_LO;
                tmr_d   = TMR_W'(STEP_PULSE - 1);
            end
            STEP_LO: begin
                if (tmr == '0) begin
                    state_d = STEP_HI;
                    tmr_d   = TMR_W'(STEP_GAP - 1);
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            STEP_HI: begin
                if (tmr == '0) begin
                    rem_d = rem - STEP_W'(1);
                    if (rem == STEP_W'(1)) begin
                        state_d = LOAD;
                    end else begin
                        state_d = STEP_LO;
                        tmr_d   = TMR_W'(STEP_PULSE - 1);
                    end
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            LOAD: state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (3'(i) == chan_q)
                            pos_d[i] = POS_W'(phase_wrap(32'(pos_q[i]), 32'(steps_q),
                                                         dir_q, PHASE_WRAP));
                    end
                end else if (timeout) begin
                    err_d         = 1'b1;
                    enter_recover = 1'b1;
                end
            end
            RECOVER: begin
                if (tmr == '0) state_d = INIT;
                else           tmr_d   = tmr - TMR_W'(1);
            end
            default: state_d = INIT;
        endcase

        // A PLL reset invalidates every tracked phase position.
        if (enter_recover) begin
            state_d = RECOVER;
            tmr_d   = TMR_W'(RST_CYCLES - 1);
            if (recover_cnt != 8'hFF) rcnt_d = recover_cnt + 8'd1;
            for (int unsigned i = 0; i < NUM_CH; i++) pos_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            tmr          <= '0;
            rem          <= '0;
            steps_q      <= '0;
            chan_q       <= '0;
            dir_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) pos_q[i] <= '0;
            recover_cnt  <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            phase_sel    <= '0;
            phase_dir    <= 1'b0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
            phase_step_n <= 1'b1;
            load_phase   <= 1'b0;
            pll_rst      <= 1'b0;
        end else begin
            state        <= state_d;
            tmr          <= tmr_d;
            rem          <= rem_d;
            steps_q      <= steps_d;
            chan_q       <= chan_d;
            dir_q        <= dir_d;
            pos_q        <= pos_d;
            recover_cnt  <= rcnt_d;
            err          <= err_d;
            done         <= done_d;
            phase_sel    <= sel_d;
            phase_dir    <= pdir_d;
            req_ready    <= (state_d == IDLE);
            busy         <= (state_d != IDLE);
            phase_step_n <= (state_d != STEP_LO);
            load_phase   <= (state_d == LOAD);
            pll_rst      <= (state_d == RECOVER);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
        assign phase_pos[g*POS_W +: POS_W] = pos_q[g];
    end

endmodule

// File: tb/tb_pll_dyn_phase_ctrl.sv
// Directed bench for pll_dyn_phase_ctrl: table of phase requests plus
// hand-written reset, lock-glitch, lock-timeout and mid-step reset sequences.
module tb_pll_dyn_phase_ctrl;

    localparam int NUM_CH = 5;
    localparam int POS_W  = 10;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_chan;
    logic                    req_dir;
    logic [7:0]              req_steps;
    logic                    done;
    logic                    err;
    logic                    busy;
    logic                    pll_lock;
    logic [2:0]              phase_sel;
    logic                    phase_dir;
    logic                    phase_step_n;
    logic                    load_phase;
    logic                    pll_rst;
    logic [NUM_CH*POS_W-1:0] phase_pos;
    logic [7:0]              recover_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] chan;
        logic       dir;
        logic [7:0] steps;
        int         chk_ch;
        int         exp_pos;
        logic       exp_err;
        int         exp_pulses;
        logic       fast;
    } vec_t;

    vec_t vecs[14];

    pll_dyn_phase_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_chan     (req_chan),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .pll_lock     (pll_lock),
        .phase_sel    (phase_sel),
        .phase_dir    (phase_dir),
        .phase_step_n (phase_step_n),
        .load_phase   (load_phase),
        .pll_rst      (pll_rst),
        .phase_pos    (phase_pos),
        .recover_cnt  (recover_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_pos(input int ch);
        logic [POS_W-1:0] p;
        p = phase_pos[ch*POS_W +: POS_W];
        return int'(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!req_ready && n < limit) begin
            tick();
            n++;
        end
        chk("req_ready_wait", int'(req_ready), 1);
    endtask

    // Leaves the caller at the sample point just after the accepting edge.
    task automatic send_req(input logic [2:0] ch, input logic d, input logic [7:0] st);
        wait_ready(200);
        req_valid = 1'b1;
        req_chan  = ch;
        req_dir   = d;
        req_steps = st;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   pulses = 0;
        int   lows   = 0;
        int   loads  = 0;
        int   lat    = 0;
        logic prev   = 1'b1;
        logic got    = 1'b0;
        send_req(v.chan, v.dir, v.steps);
        for (int c = 1; c <= 3000 && !got; c++) begin
            if (!phase_step_n) begin
                lows++;
                if (prev) pulses++;
            end
            prev = phase_step_n;
            if (load_phase) begin
                loads++;
                chk("load_sel", int'(phase_sel), int'(v.chan));
                chk("load_dir", int'(phase_dir), int'(v.dir));
            end
            if (done) begin
                got = 1'b1;
                lat = c;
            end else begin
                tick();
            end
        end
        chk("done_seen", int'(got), 1);
        chk("err", int'(err), int'(v.exp_err));
        chk("step_pulses", pulses, v.exp_pulses);
        chk("step_low_cycles", lows, 2 * v.exp_pulses);
        chk("load_pulses", loads, (v.exp_pulses > 0) ? 1 : 0);
        chk("phase_pos", get_pos(v.chk_ch), v.exp_pos);
        if (v.fast) chk("done_latency", lat, 1);
        tick();
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int   n;
        logic seen_done;
        vec_t v;

        //           chan  dir   steps  ch  pos  err   pulses fast
        vecs[0]  = '{3'd2, 1'b1, 8'd3,   2,   3, 1'b0,   3, 1'b0};
        vecs[1]  = '{3'd0, 1'b0, 8'd5,   0, 915, 1'b0,   5, 1'b0};
        vecs[2]  = '{3'd0, 1'b1, 8'd5,   0,   0, 1'b0,   5, 1'b0};
        vecs[3]  = '{3'd6, 1'b1, 8'd3,   2,   3, 1'b1,   0, 1'b1};
        vecs[4]  = '{3'd1, 1'b1, 8'd0,   1,   0, 1'b0,   0, 1'b1};
        vecs[5]  = '{3'd4, 1'b1, 8'd255, 4, 255, 1'b0, 255, 1'b0};
        vecs[6]  = '{3'd4, 1'b1, 8'd255, 4, 510, 1'b0, 255, 1'b0};
        vecs[7]  = '{3'd4, 1'b1, 8'd255, 4, 765, 1'b0, 255, 1'b0};
        vecs[8]  = '{3'd4, 1'b1, 8'd255, 4, 100, 1'b0, 255, 1'b0};
        vecs[9]  = '{3'd3, 1'b0, 8'd1,   3, 919, 1'b0,   1, 1'b0};
        vecs[10] = '{3'd3, 1'b1, 8'd1,   3,   0, 1'b0,   1, 1'b0};
        vecs[11] = '{3'd7, 1'b0, 8'd9,   4, 100, 1'b1,   0, 1'b1};
        vecs[12] = '{3'd2, 1'b0, 8'd3,   2,   0, 1'b0,   3, 1'b0};
        vecs[13] = '{3'd1, 1'b1, 8'd2,   1,   2, 1'b0,   2, 1'b0};

        rst_n     = 1'b0;
        pll_lock  = 1'b0;
        req_valid = 1'b0;
        req_chan  = '0;
        req_dir   = 1'b0;
        req_steps = '0;
        repeat (3) tick();

        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_step_n", int'(phase_step_n), 1);
        chk("rst_load", int'(load_phase), 0);
        chk("rst_pll_rst", int'(pll_rst), 0);
        chk("rst_sel", int'(phase_sel), 0);
        chk("rst_pos_zero", int'(phase_pos == '0), 1);
        chk("rst_recover_cnt", int'(recover_cnt), 0);

        // Lock rises 20 cycles after reset release; two sync flops plus the INIT->IDLE edge.
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
            if (n == 20) pll_lock = 1'b1;
        end
        chk("init_ready_cycle", n, 23);
        chk("init_busy", int'(busy), 0);
        chk("init_pos_zero", int'(phase_pos == '0), 1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Short lock glitch in IDLE must not trigger recovery.
        pll_lock = 1'b0;
        repeat (10) tick();
        pll_lock = 1'b1;
        repeat (10) tick();
        chk("glitch_ready", int'(req_ready), 1);
        chk("glitch_recover_cnt", int'(recover_cnt), 0);

        // Lock lost during stepping and never returns: timeout then PLL reset.
        send_req(3'd1, 1'b1, 8'd2);
        pll_lock  = 1'b0;
        n         = 0;
        seen_done = 1'b0;
        while (!pll_rst && n < 60000) begin
            if (done) seen_done = 1'b1;
            tick();
            n++;
        end
        chk("timeout_pll_rst", int'(pll_rst), 1);
        chk("timeout_no_done", int'(seen_done), 0);
        chk("timeout_err", int'(err), 1);
        chk("timeout_recover_cnt", int'(recover_cnt), 1);
        chk("timeout_pos_cleared", int'(phase_pos == '0), 1);
        n = 0;
        while (pll_rst && n < 200) begin
            n++;
            tick();
        end
        chk("pll_rst_cycles", n, 100);
        chk("post_recover_busy", int'(busy), 1);
        chk("post_recover_ready", int'(req_ready), 0);
        pll_lock = 1'b1;
        wait_ready(50);
        chk("err_sticky", int'(err), 1);
        chk("post_recover_pos", int'(phase_pos == '0), 1);
        chk("post_recover_cnt", int'(recover_cnt), 1);
        v = vecs[13];
        run_vec(v);

        // Async reset while a step pulse is active.
        send_req(3'd3, 1'b1, 8'd4);
        n = 0;
        while (phase_step_n && n < 20) begin
            tick();
            n++;
        end
        chk("mid_step_low", int'(phase_step_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_step_n", int'(phase_step_n), 1);
        chk("mid_rst_pll_rst", int'(pll_rst), 0);
        chk("mid_rst_busy", int'(busy), 1);
        chk("mid_rst_ready", int'(req_ready), 0);
        chk("mid_rst_pos", int'(phase_pos == '0), 1);
        chk("mid_rst_recover_cnt", int'(recover_cnt), 0);
        tick();
        rst_n = 1'b1;
        wait_ready(50);
        chk("relock_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
